// File: rtl/cache_bus_arb_pkg.sv
// ============================================================================
// cache_bus_arb_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the multicore cache-to-memory bus arbiter.
// Holds the FSM state encodings, the request packet layout used by caches,
// the bus and benches, and helper functions for the derived packet and
// beat-count widths.
//
// The packet typedef is sized for the default block of 8 words. Modules that
// are parameterised on block size use cache_bus_pkt_width() to size a flat
// vector with the same field order: {we, addr[31:0], wdata}.
// ============================================================================
package cache_bus_arb_pkg;

    localparam int addr_width         = 32;
    localparam int default_block_size = 8;

    // FSM encodings for the bus arbiter
    localparam logic [1:0] state_idle = 2'd0;
    localparam logic [1:0] state_req  = 2'd1;
    localparam logic [1:0] state_wait = 2'd2;
    localparam logic [1:0] state_done = 2'd3;

    // Cache request: write enable in the MSB, block data in the LSBs
    typedef struct packed {
        logic                                we;
        logic [addr_width-1:0]               addr;
        logic [default_block_size*32-1:0]    wdata;
    } cache_bus_pkt_t;

    // Width of a flattened request packet for an arbitrary block size
    function automatic int cache_bus_pkt_width(input int block_size);
        return 1 + addr_width + block_size * 32;
    endfunction

    // Number of memory beats needed to move one block
    function automatic int beat_count(input int block_size, input int beat_width);
        return (block_size * 32) / beat_width;
    endfunction

endpackage

// File: rtl/cache_bus_arb_rr_arbiter.sv
// ============================================================================
// rr_arbiter
// ----------------------------------------------------------------------------
// Purely combinational round-robin picker. Scans upward from ptr, wrapping
// modulo n_p, and grants the first asserted request.
//
// Ports:
//   req        in   n_p           request vector
//   ptr        in   ptr_width_lp  index where the scan starts
//   grant      out  n_p           one-hot grant (all zero if no request)
//   grant_idx  out  ptr_width_lp  index of the granted request
//   has_grant  out  1             at least one request was present
// ============================================================================
module rr_arbiter #(
    parameter  int n_p          = 4,
    localparam int ptr_width_lp = (n_p > 1) ? $clog2(n_p) : 1
) (
    input  logic [n_p-1:0]          req,
    input  logic [ptr_width_lp-1:0] ptr,
    output logic [n_p-1:0]          grant,
    output logic [ptr_width_lp-1:0] grant_idx,
    output logic                    has_grant
);

    logic [ptr_width_lp-1:0] cand;

    // Walk the candidates in priority order starting at ptr; the first hit
    // wins and later hits are masked by has_grant.
    always_comb begin
        has_grant = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < n_p; i++) begin
            cand = ptr_width_lp'((int'(ptr) + i) % n_p);
            if (!has_grant && req[cand]) begin
                has_grant = 1'b1;
                grant_idx = cand;
            end
        end
        grant = has_grant ? (n_p'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/cache_bus_arb.sv
// ============================================================================
// cache_bus_arb
// ----------------------------------------------------------------------------
// Round-robin arbiter between num_caches_p caches and main memory. A granted
// block request is serialised into dma_data_width_p-bit beats, one beat
// outstanding at a time. Read beats are returned to the owning cache one
// cycle after memory completes them; writes get a single ack pulse (data 0)
// once the last beat has been acknowledged.
//
// Ports:
//   clk_i        in   1                       clock
//   reset_i      in   1                       synchronous active-high reset
//   cb_valid_i   in   num_caches_p            per-cache request valid
//   cb_yumi_o    out  num_caches_p            one-hot request accept
//   cb_pkt_i     in   num_caches_p x pkt      per-cache {we, addr, wdata}
//   cb_valid_o   out  num_caches_p            one-hot response valid
//   cb_data_o    out  dma_data_width_p        shared response data
//   mem_valid_o  out  1                       memory beat request
//   mem_ready_i  in   1                       memory accepts the beat
//   mem_we_o     out  1                       beat is a write
//   mem_addr_o   out  32                      byte address of the beat
//   mem_wdata_o  out  dma_data_width_p        write beat data
//   mem_valid_i  in   1                       beat done (read data / ack)
//   mem_data_i   in   dma_data_width_p        read beat data
// ============================================================================
module cache_bus_arb
    import cache_bus_arb_pkg::*;
#(
    parameter  int num_caches_p     = 4,
    parameter  int block_size_p     = 8,
    parameter  int dma_data_width_p = 64,
    localparam int beats_lp         = beat_count(block_size_p, dma_data_width_p),
    localparam int pkt_width_lp     = cache_bus_pkt_width(block_size_p),
    localparam int ptr_width_lp     = (num_caches_p > 1) ? $clog2(num_caches_p) : 1,
    localparam int beat_width_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [num_caches_p-1:0]                   cb_valid_i,
    output logic [num_caches_p-1:0]                   cb_yumi_o,
    input  logic [num_caches_p-1:0][pkt_width_lp-1:0] cb_pkt_i,
    output logic [num_caches_p-1:0]                   cb_valid_o,
    output logic [dma_data_width_p-1:0]               cb_data_o,
    output logic                                      mem_valid_o,
    input  logic                                      mem_ready_i,
    output logic                                      mem_we_o,
    output logic [31:0]                               mem_addr_o,
    output logic [dma_data_width_p-1:0]               mem_wdata_o,
    input  logic                                      mem_valid_i,
    input  logic [dma_data_width_p-1:0]               mem_data_i
);

    localparam int          block_bits_lp  = block_size_p * 32;
    localparam int          beat_bytes_lp  = dma_data_width_p / 8;
    localparam logic [31:0] block_mask_lp  = ~(32'(block_size_p * 4) - 32'd1);

    logic [1:0]                  state;
    logic [ptr_width_lp-1:0]     rr_ptr;
    logic [ptr_width_lp-1:0]     grant_r;
    logic [beat_width_lp-1:0]    beat_cnt;
    logic [pkt_width_lp-1:0]     pkt_r;
    logic [num_caches_p-1:0]     cb_valid_r;
    logic [dma_data_width_p-1:0] cb_data_r;

    logic [num_caches_p-1:0]     arb_grant;
    logic [ptr_width_lp-1:0]     arb_idx;
    logic                        arb_has_grant;
    logic [num_caches_p-1:0]     grant_onehot;

    logic                        pkt_we;
    logic [31:0]                 pkt_addr;
    logic [beats_lp-1:0][dma_data_width_p-1:0] pkt_beats;

    assign pkt_we    = pkt_r[pkt_width_lp-1];
    assign pkt_addr  = pkt_r[block_bits_lp +: 32];
    assign pkt_beats = pkt_r[block_bits_lp-1:0];

    rr_arbiter #(
        .n_p(num_caches_p)
    ) arb (
        .req       (cb_valid_i),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .has_grant (arb_has_grant)
    );

    // Grants are only issued from IDLE, and never while reset is held, so a
    // cache cannot believe its request was taken when the FSM discards it.
    assign cb_yumi_o = (state == state_idle && !reset_i) ? arb_grant : '0;

    assign grant_onehot = num_caches_p'(1) << grant_r;

    // Memory side is driven only while a beat is being requested; the beat
    // address walks up from the block-aligned base.
    always_comb begin
        mem_valid_o = (state == state_req);
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state == state_req) begin
            mem_we_o   = pkt_we;
            mem_addr_o = (pkt_addr & block_mask_lp) + 32'(beat_cnt) * 32'(beat_bytes_lp);
            if (pkt_we) begin
                mem_wdata_o = pkt_beats[beat_cnt];
            end
        end
    end

    // Read beats come from the registered pulse; the write ack is decoded
    // straight from DONE. cb_data_r is cleared every cycle it is not loaded,
    // so the write ack naturally carries zero data.
    assign cb_valid_o = cb_valid_r | ((state == state_done) ? grant_onehot : '0);
    assign cb_data_o  = cb_data_r;

    // Main transaction FSM. A memory completion is only honoured in WAIT, so
    // an early or stray mem_valid_i cannot advance the beat counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= state_idle;
            rr_ptr     <= '0;
            grant_r    <= '0;
            beat_cnt   <= '0;
            pkt_r      <= '0;
            cb_valid_r <= '0;
            cb_data_r  <= '0;
        end else begin
            cb_valid_r <= '0;
            cb_data_r  <= '0;
            case (state)
                state_idle: begin
                    if (arb_has_grant) begin
                        pkt_r    <= cb_pkt_i[arb_idx];
                        grant_r  <= arb_idx;
                        beat_cnt <= '0;
                        rr_ptr   <= (arb_idx == ptr_width_lp'(num_caches_p - 1))
                                    ? '0 : arb_idx + 1'b1;
                        state    <= state_req;
                    end
                end
                state_req: begin
                    if (mem_ready_i) begin
                        state <= state_wait;
                    end
                end
                state_wait: begin
                    if (mem_valid_i) begin
                        if (!pkt_we) begin
                            cb_valid_r <= grant_onehot;
                            cb_data_r  <= mem_data_i;
                        end
                        if (beat_cnt == beat_width_lp'(beats_lp - 1)) begin
                            state <= pkt_we ? state_done : state_idle;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= state_req;
                        end
                    end
                end
                default: begin
                    state <= state_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_arb.sv
// ============================================================================
// tb_cache_bus_arb
// ----------------------------------------------------------------------------
// Directed bench for cache_bus_arb with 4 caches, 8-word blocks and 64-bit
// beats (4 beats per block). The bench plays the memory side by hand and
// knows every expected address, data word and grant in advance.
// ============================================================================
module tb_cache_bus_arb;
    import cache_bus_arb_pkg::*;

    localparam int N   = 4;
    localparam int BLK = 8;
    localparam int DW  = 64;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [N-1:0]         cb_valid_i;
    logic [N-1:0]         cb_yumi_o;
    cache_bus_pkt_t [N-1:0] cb_pkt;
    logic [N-1:0]         cb_valid_o;
    logic [DW-1:0]        cb_data_o;
    logic                 mem_valid_o;
    logic                 mem_ready_i;
    logic                 mem_we_o;
    logic [31:0]          mem_addr_o;
    logic [DW-1:0]        mem_wdata_o;
    logic                 mem_valid_i;
    logic [DW-1:0]        mem_data_i;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk_i = ~clk_i;

    cache_bus_arb #(
        .num_caches_p     (N),
        .block_size_p     (BLK),
        .dma_data_width_p (DW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cb_valid_i  (cb_valid_i),
        .cb_yumi_o   (cb_yumi_o),
        .cb_pkt_i    (cb_pkt),
        .cb_valid_o  (cb_valid_o),
        .cb_data_o   (cb_data_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_valid_i (mem_valid_i),
        .mem_data_i  (mem_data_i)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Everything is driven and sampled on the falling edge
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic applyReset();
        reset_i     = 1'b1;
        cb_valid_i  = '0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Present a block request from one cache; data words are wordBase+i
    task automatic applyStimulus(input int cache, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wordBase);
        cb_pkt[cache].we   = we;
        cb_pkt[cache].addr = addr;
        for (int w = 0; w < BLK; w++) begin
            cb_pkt[cache].wdata[w*32 +: 32] = wordBase + 32'(w);
        end
        cb_valid_i[cache] = 1'b1;
    endtask

    // Play memory for one beat: find the request, optionally stall ready and
    // the completion, then check what the cache side sees the cycle after.
    task automatic serveBeat(input string tag, input int readyDelay, input int ackDelay,
                             input logic [31:0] expAddr, input logic expWe,
                             input logic [63:0] expWdata, input logic [63:0] rdata,
                             input logic [N-1:0] expCbValid, input logic [63:0] expCbData,
                             input bit spurious);
        int waitCycles;
        waitCycles = 0;
        while (mem_valid_o !== 1'b1 && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput($sformatf("%s mem_valid", tag), mem_valid_o, 1);
        if (mem_valid_o !== 1'b1) return;
        checkOutput($sformatf("%s addr", tag), mem_addr_o, expAddr);
        checkOutput($sformatf("%s we", tag), mem_we_o, expWe);
        if (expWe) checkOutput($sformatf("%s wdata", tag), mem_wdata_o, expWdata);
        for (int i = 0; i < readyDelay; i++) begin
            mem_ready_i = 1'b0;
            mem_valid_i = spurious && (i == 0);
            mem_data_i  = 64'hdead_beef_dead_beef;
            tick();
            mem_valid_i = 1'b0;
            mem_data_i  = '0;
            checkOutput($sformatf("%s hold valid", tag), mem_valid_o, 1);
            checkOutput($sformatf("%s hold addr", tag), mem_addr_o, expAddr);
            checkOutput($sformatf("%s stall cb", tag), cb_valid_o, 0);
        end
        mem_ready_i = 1'b1;
        mem_valid_i = spurious;
        mem_data_i  = 64'hdead_beef_dead_beef;
        tick();
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        checkOutput($sformatf("%s in wait", tag), mem_valid_o, 0);
        for (int i = 0; i < ackDelay; i++) begin
            tick();
            checkOutput($sformatf("%s ack wait cb", tag), cb_valid_o, 0);
            checkOutput($sformatf("%s ack wait mem", tag), mem_valid_o, 0);
        end
        mem_valid_i = 1'b1;
        mem_data_i  = rdata;
        tick();
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        checkOutput($sformatf("%s cb_valid", tag), cb_valid_o, expCbValid);
        checkOutput($sformatf("%s cb_data", tag), cb_data_o, expCbData);
    endtask

    function automatic logic [63:0] readPattern(input int cache, input int beat);
        return 64'hA5A5_0000_0000_0000 | (64'(cache) << 16) | 64'(beat);
    endfunction

    // Full four-beat read of the block containing addr, echoing readPattern
    task automatic doRead(input string tag, input int cache, input logic [31:0] addr,
                          input int readyDelay, input int ackDelay, input bit spurious);
        logic [31:0] base;
        base = addr & ~32'h1F;
        for (int b = 0; b < 4; b++) begin
            serveBeat($sformatf("%s b%0d", tag, b), readyDelay, ackDelay,
                      base + 32'(8 * b), 1'b0, 64'h0, readPattern(cache, b),
                      N'(1) << cache, readPattern(cache, b), spurious);
        end
    endtask

    // Watchdog so a stuck handshake still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expOrder[4];
        expOrder = '{0, 1, 3, 0};
        cb_pkt   = '0;
        applyReset();

        // Reset state
        checkOutput("reset mem_valid", mem_valid_o, 0);
        checkOutput("reset mem_we", mem_we_o, 0);
        checkOutput("reset mem_addr", mem_addr_o, 0);
        checkOutput("reset cb_valid", cb_valid_o, 0);
        checkOutput("reset cb_data", cb_data_o, 0);
        checkOutput("reset yumi", cb_yumi_o, 0);

        // Single read from cache 0 at 0x104: block base 0x100
        applyStimulus(0, 1'b0, 32'h104, 32'h0);
        #1 checkOutput("read yumi", cb_yumi_o, 4'b0001);
        tick();
        cb_valid_i = '0;
        checkOutput("read latency", mem_valid_o, 1);
        doRead("read", 0, 32'h104, 0, 0, 1'b0);
        tick();
        checkOutput("read no extra cb", cb_valid_o, 0);
        checkOutput("read no extra mem", mem_valid_o, 0);

        // Stray completion while idle must not produce a response
        mem_valid_i = 1'b1;
        mem_data_i  = 64'h1234;
        tick();
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        checkOutput("idle spurious cb", cb_valid_o, 0);
        checkOutput("idle spurious mem", mem_valid_o, 0);

        // Single write from cache 2 at 0x200 with words 0..7
        applyStimulus(2, 1'b1, 32'h200, 32'h0);
        #1 checkOutput("write yumi", cb_yumi_o, 4'b0100);
        tick();
        cb_valid_i = '0;
        for (int b = 0; b < 4; b++) begin
            serveBeat($sformatf("write b%0d", b), 0, 1, 32'h200 + 32'(8 * b), 1'b1,
                      {32'(2 * b + 1), 32'(2 * b)}, 64'hFFFF_FFFF_FFFF_FFFF,
                      (b == 3) ? 4'b0100 : 4'b0000, 64'h0, 1'b0);
        end
        tick();
        checkOutput("write after done", cb_valid_o, 0);

        // Fairness: caches 0, 1, 3 request continuously
        applyReset();
        applyStimulus(0, 1'b0, 32'h000, 32'h0);
        applyStimulus(1, 1'b0, 32'h040, 32'h0);
        applyStimulus(3, 1'b0, 32'h0C0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1 checkOutput($sformatf("fair grant%0d", k), cb_yumi_o, N'(1) << expOrder[k]);
            tick();
            checkOutput($sformatf("fair busy%0d", k), cb_yumi_o, 0);
            doRead($sformatf("fair%0d", k), expOrder[k],
                   32'(expOrder[k]) * 32'h40, 0, 0, 1'b0);
        end
        cb_valid_i = '0;
        tick();
        checkOutput("fair drained", mem_valid_o, 0);

        // Back-pressure with stray completions during REQ
        applyReset();
        applyStimulus(1, 1'b0, 32'h48, 32'h0);
        #1 checkOutput("bp yumi", cb_yumi_o, 4'b0010);
        tick();
        cb_valid_i = '0;
        doRead("bp", 1, 32'h48, 5, 3, 1'b1);
        tick();
        checkOutput("bp no extra mem", mem_valid_o, 0);
        checkOutput("bp no extra cb", cb_valid_o, 0);

        // Reset in the middle of a read, after beat 1 returns
        applyStimulus(0, 1'b0, 32'h104, 32'h0);
        #1 checkOutput("rst yumi", cb_yumi_o, 4'b0001);
        tick();
        cb_valid_i = '0;
        for (int b = 0; b < 2; b++) begin
            serveBeat($sformatf("rst b%0d", b), 0, 0, 32'h100 + 32'(8 * b), 1'b0, 64'h0,
                      readPattern(0, b), 4'b0001, readPattern(0, b), 1'b0);
        end
        reset_i = 1'b1;
        tick();
        checkOutput("rst mem_valid", mem_valid_o, 0);
        checkOutput("rst mem_addr", mem_addr_o, 0);
        checkOutput("rst cb_valid", cb_valid_o, 0);
        checkOutput("rst cb_data", cb_data_o, 0);
        reset_i = 1'b0;
        applyStimulus(0, 1'b0, 32'h104, 32'h0);
        applyStimulus(1, 1'b0, 32'h040, 32'h0);
        #1 checkOutput("rst ptr grant", cb_yumi_o, 4'b0001);
        tick();
        cb_valid_i = '0;
        doRead("rst again", 0, 32'h104, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
